// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: word width and data-side FSM encoding.
package data_mem_responder_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } dmr_state_t;

endpackage

// File: rtl/data_mem_responder_mem_array_2p.sv
// Word storage with a synchronous fetch read port and a synchronous data read/write port.
// The array itself is never reset; only the read-data registers are.
module mem_array_2p
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_f_re,
    input  logic [AW-1:0]     i_f_idx,
    output logic [WORD_W-1:0] o_f_rdata,
    input  logic              i_d_re,
    input  logic              i_d_we,
    input  logic              i_d_clr,
    input  logic [AW-1:0]     i_d_idx,
    input  logic [WORD_W-1:0] i_d_wdata,
    output logic [WORD_W-1:0] o_d_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
    logic [WORD_W-1:0] r_f_rdata;
    logic [WORD_W-1:0] r_d_rdata;

    always_ff @(posedge clk) begin
        if (i_d_we) begin
            r_mem[i_d_idx] <= i_d_wdata;
        end
    end

    // Non-blocking reads give read-before-write when a fetch hits the word being stored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_f_rdata <= '0;
        end else if (i_f_re) begin
            r_f_rdata <= r_mem[i_f_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_d_rdata <= '0;
        end else if (i_d_clr) begin
            r_d_rdata <= '0;
        end else if (i_d_re) begin
            r_d_rdata <= r_mem[i_d_idx];
        end
    end

    assign o_f_rdata = r_f_rdata;
    assign o_d_rdata = r_d_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Memory responder: single-cycle instruction fetch port plus a latency-programmable
// data load/store port that pulses data_ready (and addr_err on rejection) per access.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned RD_LATENCY  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_read,
    input  logic [31:0]       instr_addr,
    output logic [WORD_W-1:0] instr_out,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [31:0]       data_addr,
    input  logic [WORD_W-1:0] data_in,
    output logic [WORD_W-1:0] data_out,
    output logic              data_ready,
    output logic              addr_err
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [1:0]  LAT_INIT = 2'(RD_LATENCY - 1);

    dmr_state_t        r_state, w_state_nxt;
    logic [1:0]        r_cnt, w_cnt_nxt;
    logic              w_capture;
    logic [AW-1:0]     r_idx;
    logic [WORD_W-1:0] r_wdata;
    logic              r_is_wr;
    logic              r_err;
    logic              r_data_ready;
    logic              r_addr_err;
    logic              w_done;
    logic              w_d_we;
    logic              w_d_re;
    logic              w_d_clr;
    logic              w_unused;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (data_read || data_write) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = LAT_INIT;
                    w_state_nxt = (RD_LATENCY == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                w_cnt_nxt = (r_cnt == '0) ? '0 : r_cnt - 2'd1;
                if (r_cnt <= 2'd1) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idx   <= '0;
            r_wdata <= '0;
            r_is_wr <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_capture) begin
            r_idx   <= data_addr[AW+1:2];
            r_wdata <= data_in;
            r_is_wr <= data_write;
            r_err   <= (data_addr[1:0] != 2'b00) || (data_read && data_write);
        end
    end

    assign w_done  = (r_state == DONE);
    // Store is gated by rst so an access aborted on its DONE edge never commits.
    assign w_d_we  = w_done && r_is_wr && !r_err && rst;
    assign w_d_re  = w_done && !r_is_wr && !r_err;
    assign w_d_clr = w_done && r_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data_ready <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            r_data_ready <= w_done;
            r_addr_err   <= w_done && r_err;
        end
    end

    mem_array_2p #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .i_f_re    (instr_read),
        .i_f_idx   (instr_addr[AW+1:2]),
        .o_f_rdata (instr_out),
        .i_d_re    (w_d_re),
        .i_d_we    (w_d_we),
        .i_d_clr   (w_d_clr),
        .i_d_idx   (r_idx),
        .i_d_wdata (r_wdata),
        .o_d_rdata (data_out)
    );

    assign data_ready = r_data_ready;
    assign addr_err   = r_addr_err;
    assign w_unused   = ^{instr_addr[31:AW+2], instr_addr[1:0], data_addr[31:AW+2]};

endmodule

// File: tb/tb_data_mem_responder.sv
// Drives three responders (RD_LATENCY 1, 3, 4) with shared stimulus and compares every
// output each cycle against a per-instance transaction-level model.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT [3] = '{1, 3, 4};

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_read;
    logic [31:0] instr_addr;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic [31:0] instr_out [3];
    logic [31:0] data_out  [3];
    logic        data_ready[3];
    logic        addr_err  [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_responder #(
            .DEPTH_WORDS (DEPTH),
            .RD_LATENCY  (LAT[g])
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .instr_read (instr_read),
            .instr_addr (instr_addr),
            .instr_out  (instr_out[g]),
            .data_read  (data_read),
            .data_write (data_write),
            .data_addr  (data_addr),
            .data_in    (data_in),
            .data_out   (data_out[g]),
            .data_ready (data_ready[g]),
            .addr_err   (addr_err[g])
        );
    end

    int n_checks = 0;
    int n_errors = 0;

    // Model: memory image per instance plus the one access in flight (cycles remaining).
    logic [31:0] ref_mem [3][DEPTH];
    int          rem     [3];
    bit          p_wr    [3];
    bit          p_err   [3];
    int          p_idx   [3];
    logic [31:0] p_data  [3];
    logic [31:0] e_instr [3];
    logic [31:0] e_dout  [3];
    logic        e_rdy   [3];
    logic        e_err   [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock edge, update the model, and compare all outputs of all instances.
    task automatic step();
        for (int k = 0; k < 3; k++) begin
            e_rdy[k] = 1'b0;
            e_err[k] = 1'b0;
            if (!rst) begin
                rem[k]     = 0;
                e_instr[k] = '0;
                e_dout[k]  = '0;
            end else begin
                if (instr_read) e_instr[k] = ref_mem[k][instr_addr[11:2]];
                if (rem[k] == 0) begin
                    if (data_read || data_write) begin
                        rem[k]    = LAT[k];
                        p_err[k]  = (data_addr[1:0] != 2'b00) || (data_read && data_write);
                        p_wr[k]   = data_write;
                        p_idx[k]  = int'(data_addr[11:2]);
                        p_data[k] = data_in;
                    end
                end else begin
                    rem[k]--;
                    if (rem[k] == 0) begin
                        e_rdy[k] = 1'b1;
                        if (p_err[k]) begin
                            e_err[k]  = 1'b1;
                            e_dout[k] = '0;
                        end else if (p_wr[k]) begin
                            ref_mem[k][p_idx[k]] = p_data[k];
                        end else begin
                            e_dout[k] = ref_mem[k][p_idx[k]];
                        end
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("instr_out[L%0d]", LAT[k]), instr_out[k], e_instr[k]);
            check($sformatf("data_out[L%0d]", LAT[k]), data_out[k], e_dout[k]);
            check($sformatf("data_ready[L%0d]", LAT[k]), 32'(data_ready[k]), 32'(e_rdy[k]));
            check($sformatf("addr_err[L%0d]", LAT[k]), 32'(addr_err[k]), 32'(e_err[k]));
        end
        @(negedge clk);
    endtask

    task automatic req(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
        data_read  = rd;
        data_write = wr;
        data_addr  = addr;
        data_in    = wdata;
        step();
        data_read  = 1'b0;
        data_write = 1'b0;
        for (int i = 0; i < 6; i++) step();
    endtask

    logic [31:0] v;
    logic [31:0] old4;
    logic [31:0] old16;

    initial begin
        rst        = 1'b0;
        instr_read = 1'b0;
        instr_addr = '0;
        data_read  = 1'b0;
        data_write = 1'b0;
        data_addr  = '0;
        data_in    = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            v = (i == 8) ? 32'h1234_5678 : $urandom;
            for (int k = 0; k < 3; k++) ref_mem[k][i] = v;
            g_dut[0].u_dut.u_mem.r_mem[i] = v;
            g_dut[1].u_dut.u_mem.r_mem[i] = v;
            g_dut[2].u_dut.u_mem.r_mem[i] = v;
        end
        old4  = ref_mem[0][1];
        old16 = ref_mem[0][16];

        step();
        step();
        rst = 1'b1;
        step();

        // Store then load, read with a stray store held into the busy window, then reload.
        req(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        req(1'b1, 1'b0, 32'h10, '0);
        for (int k = 0; k < 3; k++) check("load_0x10", data_out[k], 32'hDEAD_BEEF);
        data_read = 1'b1; data_addr = 32'h20;
        step();
        data_read = 1'b0; data_write = 1'b1; data_in = 32'h0BAD_0BAD;
        step();
        data_write = 1'b0;
        for (int i = 0; i < 6; i++) step();
        for (int k = 0; k < 3; k++) check("load_0x20", data_out[k], 32'h1234_5678);
        req(1'b1, 1'b0, 32'h20, '0);
        for (int k = 0; k < 3; k++) check("reload_0x20", data_out[k], 32'h1234_5678);

        // Rejected accesses leave memory untouched and zero data_out.
        req(1'b0, 1'b1, 32'h13, 32'hFFFF_FFFF);
        for (int k = 0; k < 3; k++) check("misaligned_dout", data_out[k], '0);
        req(1'b1, 1'b0, 32'h10, '0);
        for (int k = 0; k < 3; k++) check("word4_kept", data_out[k], 32'hDEAD_BEEF);
        req(1'b1, 1'b1, 32'h8, 32'h7777_7777);
        for (int k = 0; k < 3; k++) check("rdwr_dout", data_out[k], '0);

        // Fetch stream racing a store to 0x4 (commits on the second fetch edge for L1).
        instr_read = 1'b1; instr_addr = 32'h0;
        data_write = 1'b1; data_addr = 32'h4; data_in = 32'h55;
        step();
        data_write = 1'b0; instr_addr = 32'h4;
        step();
        check("fetch4_old", instr_out[0], old4);
        step();
        check("fetch4_new", instr_out[0], 32'h55);
        instr_addr = 32'h8;
        for (int i = 0; i < 6; i++) step();
        instr_read = 1'b0;

        // Address wrap beyond the array.
        req(1'b0, 1'b1, 32'h1000, 32'hA5A5_A5A5);
        req(1'b1, 1'b0, 32'h0, '0);
        for (int k = 0; k < 3; k++) check("wrap_0x0", data_out[k], 32'hA5A5_A5A5);

        // Reset during WAIT aborts the pending store for the slower instances.
        data_write = 1'b1; data_addr = 32'h40; data_in = 32'hCAFE_F00D;
        step();
        data_write = 1'b0;
        step();
        rst = 1'b0;
        step();
        check("rst_dout_L4", data_out[2], '0);
        check("rst_ready_L4", 32'(data_ready[2]), '0);
        rst = 1'b1;
        req(1'b1, 1'b0, 32'h40, '0);
        check("abort_L4_kept", data_out[2], old16);
        check("abort_L3_kept", data_out[1], old16);
        check("commit_L1", data_out[0], 32'hCAFE_F00D);

        // Randomized traffic: fetches, loads, stores, rejects, overlap, occasional reset.
        for (int c = 0; c < 800; c++) begin
            rst        = ($urandom_range(0, 79) != 0);
            instr_read = $urandom_range(0, 1) == 1;
            instr_addr = $urandom;
            data_read  = 1'b0;
            data_write = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: data_read = 1'b1;
                    4, 5, 6, 7, 8: data_write = 1'b1;
                    default: begin data_read = 1'b1; data_write = 1'b1; end
                endcase
            end
            data_addr = {$urandom_range(0, 3), 18'd0, $urandom_range(0, 31), 2'b00};
            if ($urandom_range(0, 7) == 0) data_addr[1:0] = 2'($urandom_range(1, 3));
            data_in = $urandom;
            step();
        end
        rst        = 1'b1;
        data_read  = 1'b0;
        data_write = 1'b0;
        for (int i = 0; i < 6; i++) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the storage array (power of two).
REQ-002 Parameter RD_LATENCY, default 1, cycles from data request capture to data_ready (legal 1..4).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 instr_read  input  1  instruction fetch request.
REQ-006 instr_addr  input  32  fetch byte address.
REQ-007 instr_out  output  32  fetched instruction word.
REQ-008 data_read  input  1  data load request.
REQ-009 data_write  input  1  data store request.
REQ-010 data_addr  input  32  load/store byte address.
REQ-011 data_in  input  32  store data.
REQ-012 data_out  output  32  load data.
REQ-013 data_ready  output  1  one-cycle pulse: data access complete, data_out valid for that cycle and held after.
REQ-014 addr_err  output  1  one-cycle pulse coincident with data_ready: rejected access.

Function
REQ-015 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap-around modulo array size).
REQ-016 Fetch port: instr_read high at edge N -> instr_out = mem[index] after edge N; instr_read low -> instr_out holds; fixed 1-cycle latency, no stall, independent of data FSM.
REQ-017 Data FSM states IDLE, WAIT, DONE.
REQ-018 IDLE: data_read or data_write high at edge -> capture address, data, and type; load latency counter with RD_LATENCY-1; go WAIT, or DONE if RD_LATENCY=1.
REQ-019 WAIT: decrement counter each cycle; counter reaching 0 -> DONE.
REQ-020 DONE: assert data_ready for exactly one cycle; return to IDLE next edge.
REQ-021 Store commits mem[index] <= captured data_in on the DONE edge; a load drives data_out from mem[index] read at that same edge.
REQ-022 Requests arriving in WAIT or DONE SHALL be ignored (no queueing); requester holds or re-asserts.
REQ-023 Misaligned address (addr[1:0] != 0) or data_read and data_write both high at capture -> access rejected: no memory write, data_out <= 0, addr_err and data_ready pulse in DONE.
REQ-024 Same-edge fetch and committing store to one word -> instr_out returns pre-store value (read-before-write).
REQ-025 Loads are 32-bit only; no byte/halfword lanes.

Reset
REQ-026 rst low at edge -> state IDLE, counter 0, instr_out 0, data_out 0, data_ready 0, addr_err 0.
REQ-027 Reset during WAIT/DONE SHALL abort access; pending store never commits.
REQ-028 Memory array contents SHALL NOT be reset; a bench initialises memory via hierarchical preload.

Structure
REQ-029 Shared package holds FSM state encoding (IDLE=2'b00, WAIT=2'b01, DONE=2'b10) and the word width constant 32.
REQ-030 One sub-module, mem_array_2p: storage with one sync read port (fetch) and one sync read/write port (data).

Verification
REQ-031 Store 0xDEADBEEF to 0x10 then load 0x10, RD_LATENCY=1 -> data_ready one cycle after each capture; load returns 0xDEADBEEF; addr_err 0.
REQ-032 RD_LATENCY=3, load 0x20 (preloaded 0x12345678) -> data_ready exactly 3 cycles after capture, data_out=0x12345678; second request in WAIT ignored.
REQ-033 Store to 0x13 -> addr_err=1, data_ready=1, data_out=0, mem[4] unchanged; both read and write high at 0x8 -> addr_err=1, mem[2] unchanged.
REQ-034 Continuous fetch 0x0,0x4,0x8 with a store 0x55 to 0x4 committing at the 0x4 fetch edge -> first fetch of 0x4 returns old value, next returns 0x55.
REQ-035 Store 0xA5A5A5A5 to 0x1000 with DEPTH_WORDS=1024 -> load of 0x0 returns 0xA5A5A5A5 (wrap).
REQ-036 Reset asserted during WAIT of a store, RD_LATENCY=4 -> all outputs 0 next cycle, target word keeps prior value.
